// File: rtl/renode_pkg.sv
// Shared types for the renode co-simulation bus requesters.
// Default-width address/data types and the APB requester state encoding.
package renode_pkg;

  localparam int AddressWidthDefault = 32;
  localparam int DataWidthDefault    = 32;

  typedef logic [AddressWidthDefault-1:0] address_t;
  typedef logic [DataWidthDefault-1:0]    data_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    RESPOND = 2'd3
  } apb_requester_state_e;

endpackage

// File: rtl/renode_timeout_counter.sv
// Wait-cycle counter shared by the bus requesters: expired is raised while the
// count sits at Limit-1, so Limit enabled cycles elapse before a requester gives up.
module renode_timeout_counter #(
  parameter int Limit = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (Limit == 0) begin : g_off
    assign expired = 1'b0;
  end else begin : g_on
    localparam int CntW = (Limit > 1) ? $clog2(Limit) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Limit - 1);

    logic [CntW-1:0] cnt_q;

    assign expired = (cnt_q == LastCnt);

    // Saturates at LastCnt so expired stays up until the owner clears it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (clear) begin
        cnt_q <= '0;
      end else if (enable && !expired) begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/renode_apb3_requester.sv
// APB3 requester behind the co-simulation bus controller: one request at a time,
// SETUP/ACCESS on APB, registered response with slave-error and timeout status.
module renode_apb3_requester
  import renode_pkg::*;
#(
  parameter int AddressWidth  = AddressWidthDefault,
  parameter int DataWidth     = DataWidthDefault,
  parameter int TimeoutCycles = 100
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [AddressWidth-1:0] req_address,
  input  logic [DataWidth-1:0]    req_data,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DataWidth-1:0]    resp_data,
  output logic                    resp_error,
  output logic                    resp_timeout,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [AddressWidth-1:0] paddr,
  output logic [DataWidth-1:0]    pwdata,
  input  logic [DataWidth-1:0]    prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  apb_requester_state_e state_q;

  logic                    psel_q, penable_q, pwrite_q;
  logic [AddressWidth-1:0] paddr_q;
  logic [DataWidth-1:0]    pwdata_q;
  logic                    resp_valid_q, resp_error_q, resp_timeout_q;
  logic [DataWidth-1:0]    resp_data_q;

  logic cnt_clear, cnt_enable, cnt_expired;

  // Counter only runs across ACCESS wait states; everywhere else it is held at zero.
  assign cnt_clear  = (state_q != ACCESS);
  assign cnt_enable = (state_q == ACCESS) && !pready;

  renode_timeout_counter #(
    .Limit (TimeoutCycles)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .expired (cnt_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      psel_q         <= 1'b0;
      penable_q      <= 1'b0;
      pwrite_q       <= 1'b0;
      paddr_q        <= '0;
      pwdata_q       <= '0;
      resp_valid_q   <= 1'b0;
      resp_error_q   <= 1'b0;
      resp_timeout_q <= 1'b0;
      resp_data_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q  <= SETUP;
            psel_q   <= 1'b1;
            pwrite_q <= req_write;
            paddr_q  <= req_address;
            pwdata_q <= req_data;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          // pready takes priority over an expiring counter on the same edge.
          if (pready) begin
            state_q        <= RESPOND;
            psel_q         <= 1'b0;
            penable_q      <= 1'b0;
            resp_valid_q   <= 1'b1;
            resp_error_q   <= pslverr;
            resp_timeout_q <= 1'b0;
            resp_data_q    <= (pwrite_q || pslverr) ? '0 : prdata;
          end else if (cnt_expired) begin
            state_q        <= RESPOND;
            psel_q         <= 1'b0;
            penable_q      <= 1'b0;
            resp_valid_q   <= 1'b1;
            resp_error_q   <= 1'b1;
            resp_timeout_q <= 1'b1;
            resp_data_q    <= '0;
          end
        end
        RESPOND: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign psel         = psel_q;
  assign penable      = penable_q;
  assign pwrite       = pwrite_q;
  assign paddr        = paddr_q;
  assign pwdata       = pwdata_q;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign resp_error   = resp_error_q;
  assign resp_timeout = resp_timeout_q;

endmodule

// File: tb/tb_renode_apb3_requester.sv
// Randomized bench for renode_apb3_requester with a transaction-timeline model:
// expected bus/response activity is derived from each request's wait/hold counts.
module tb_renode_apb3_requester;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_address = '0, req_data = '0;
  logic        resp_valid, resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        resp_error, resp_timeout;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0, pslverr = 1'b0;

  always #5 clk = ~clk;

  renode_apb3_requester #(
    .AddressWidth (32),
    .DataWidth    (32),
    .TimeoutCycles(T)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_error(resp_error), .resp_timeout(resp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  int n_checks = 0, n_err = 0;
  int cyc = 0, acc_cyc = 0;
  bit active = 1'b0;

  // Parameters of the transaction in flight.
  bit          t_write, t_err;
  logic [31:0] t_addr, t_data, t_rdata;
  int          t_wait, t_hold;

  // What the DUT actually did for the current transaction.
  int          obs_resp_i, obs_psel_n;
  bit          seen_resp;
  logic [31:0] obs_data;
  logic        obs_err, obs_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ACCESS length: completes in cycle wait+1 unless the timeout ends it after T cycles.
  function automatic int acc_len(input int w);
    return (w < T) ? w + 1 : T;
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  always @(negedge clk) begin : cmp
    int  i, L;
    bit  ps, pe, rv, rr, to;
    logic [31:0] exp_data;
    if (rst_n) begin
      i = 0; L = 0; to = 0;
      ps = 0; pe = 0; rv = 0; rr = 1;
      if (active) begin
        i  = cyc - acc_cyc;
        L  = acc_len(t_wait);
        to = (t_wait >= T);
        ps = (i <= L);
        pe = (i >= 1) && (i <= L);
        rv = (i >= L + 1) && (i <= L + 1 + t_hold);
        rr = (i >= L + 2 + t_hold);
        if (i == 0) begin
          seen_resp  = 0;
          obs_psel_n = 0;
        end
        if (psel === 1'b1) obs_psel_n++;
        if (resp_valid === 1'b1 && !seen_resp) begin
          seen_resp  = 1;
          obs_resp_i = i;
          obs_data   = resp_data;
          obs_err    = resp_error;
          obs_to     = resp_timeout;
        end
      end
      chk("psel", 32'(psel), 32'(ps));
      chk("penable", 32'(penable), 32'(pe));
      chk("resp_valid", 32'(resp_valid), 32'(rv));
      chk("req_ready", 32'(req_ready), 32'(rr));
      if (active) begin
        chk("paddr", paddr, t_addr);
        chk("pwrite", 32'(pwrite), 32'(t_write));
        chk("pwdata", pwdata, t_data);
      end
      if (rv) begin
        exp_data = (t_write || to || t_err) ? 32'h0 : t_rdata;
        chk("resp_data", resp_data, exp_data);
        chk("resp_error", 32'(resp_error), 32'(to || t_err));
        chk("resp_timeout", 32'(resp_timeout), 32'(to));
      end
    end
  end

  task automatic run_txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rd, input int wt, input bit er,
                         input int hold, input bit busy_req, input int abort_at);
    int L;
    L = acc_len(wt);
    req_valid   = 1'b1;
    req_write   = w;
    req_address = a;
    req_data    = d;
    pready      = 1'($urandom);
    pslverr     = 1'($urandom);
    prdata      = $urandom;
    resp_ready  = 1'($urandom);
    tick();
    active  = 1'b1;
    acc_cyc = cyc;
    t_write = w; t_addr = a; t_data = d; t_rdata = rd;
    t_wait  = wt; t_err = er; t_hold = hold;
    for (int i = 0; i <= L + 1 + hold; i++) begin
      req_valid   = busy_req ? 1'b1 : 1'($urandom);
      req_write   = 1'($urandom);
      req_address = $urandom;
      req_data    = $urandom;
      if (i >= 1 && i <= L) begin
        pready  = (i == wt + 1);
        pslverr = (i == wt + 1) ? er : 1'($urandom);
        prdata  = (i == wt + 1) ? rd : $urandom;
      end else begin
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = $urandom;
      end
      resp_ready = (i >= L + 1) ? (i == L + 1 + hold) : 1'($urandom);
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_psel", 32'(psel), 32'd0);
        chk("abort_penable", 32'(penable), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_paddr", paddr, 32'd0);
        active    = 1'b0;
        req_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        return;
      end
      tick();
    end
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_error", 32'(resp_error), 32'd0);
    chk("rst_resp_timeout", 32'(resp_timeout), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // Zero-wait write: response three cycles after the request cycle.
    run_txn(1'b1, 32'h1000, 32'hDEADBEEF, 32'h0, 0, 1'b0, 0, 1'b0, -1);
    chk("wr_latency", 32'(obs_resp_i), 32'd2);
    chk("wr_psel_cycles", 32'(obs_psel_n), 32'd2);
    chk("wr_error", 32'(obs_err), 32'd0);

    // Read with three wait states.
    run_txn(1'b0, 32'h2004, 32'h0, 32'h12345678, 3, 1'b0, 0, 1'b0, -1);
    chk("rd_latency", 32'(obs_resp_i), 32'd5);
    chk("rd_data", obs_data, 32'h12345678);

    // Slave error on read completion.
    run_txn(1'b0, 32'h3000, 32'h0, 32'hCAFEF00D, 1, 1'b1, 0, 1'b0, -1);
    chk("slverr_error", 32'(obs_err), 32'd1);
    chk("slverr_timeout", 32'(obs_to), 32'd0);
    chk("slverr_data", obs_data, 32'd0);

    // pready stuck low: four ACCESS cycles then timeout.
    run_txn(1'b0, 32'h4000, 32'h0, 32'h55AA55AA, 1000, 1'b0, 1, 1'b0, -1);
    chk("to_psel_cycles", 32'(obs_psel_n), 32'd5);
    chk("to_latency", 32'(obs_resp_i), 32'd5);
    chk("to_flags", {30'd0, obs_err, obs_to}, 32'd3);
    chk("to_data", obs_data, 32'd0);

    // pready on the last permitted ACCESS cycle completes normally.
    run_txn(1'b0, 32'h4004, 32'h0, 32'h0BADBEEF, T - 1, 1'b0, 0, 1'b0, -1);
    chk("edge_timeout", 32'(obs_to), 32'd0);
    chk("edge_data", obs_data, 32'h0BADBEEF);

    // Response held for ten cycles with new requests hammering the input.
    run_txn(1'b1, 32'h5000, 32'h11112222, 32'h0, 2, 1'b0, 10, 1'b1, -1);
    run_txn(1'b0, 32'h5004, 32'h0, 32'h33334444, 0, 1'b0, 0, 1'b0, -1);
    chk("after_hold_latency", 32'(obs_resp_i), 32'd2);

    // Reset in the middle of ACCESS, then a clean read.
    run_txn(1'b0, 32'h6000, 32'h0, 32'h77778888, 5, 1'b0, 0, 1'b0, 2);
    run_txn(1'b0, 32'h6004, 32'h0, 32'h9999AAAA, 1, 1'b0, 0, 1'b0, -1);
    chk("post_rst_data", obs_data, 32'h9999AAAA);
    chk("post_rst_latency", 32'(obs_resp_i), 32'd3);

    for (int n = 0; n < 150; n++) begin
      int gap;
      run_txn(1'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(0, 6)),
              ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), 1'b0, -1);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        req_valid = 1'b0;
        pready    = 1'($urandom);
        prdata    = $urandom;
        tick();
      end
    end

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/renode_apb3_requester.md
# renode_apb3_requester

Synthesizable APB3 requester sitting directly downstream of the co-simulation bus controller. Accepts one read or write request at a time over a valid/ready channel, runs the APB3 SETUP/ACCESS sequence against the peripheral under test, and returns a registered response carrying read data, slave error and timeout status. The bus controller's read/write tasks drive the request side and block on the response side, so the co-simulation bridge never stalls on a hung peripheral.

## Interface
Parameters:
- AddressWidth, 32, width of req_address/paddr
- DataWidth, 32, width of req_data/resp_data/pwdata/prdata
- TimeoutCycles, 100, maximum ACCESS cycles without pready; 0 disables timeout

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block idle and accepting
- req_write  input  1  1 = write, 0 = read
- req_address  input  AddressWidth  target address
- req_data  input  DataWidth  write data (ignored for reads)
- resp_valid  output  1  response present
- resp_ready  input  1  response consumed
- resp_data  output  DataWidth  read data; 0 for writes and errors
- resp_error  output  1  pslverr or timeout
- resp_timeout  output  1  timeout occurred (implies resp_error)
- psel, penable, pwrite  output  1  APB3 control
- paddr  output  AddressWidth  APB3 address
- pwdata  output  DataWidth  APB3 write data
- prdata  input  DataWidth  APB3 read data
- pready  input  1  APB3 ready
- pslverr  input  1  APB3 slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESPOND.
- IDLE: req_ready=1. On req_valid: latch write/address/data into paddr/pwrite/pwdata, go SETUP.
- SETUP: psel=1, penable=0, one cycle, go ACCESS; timeout counter cleared.
- ACCESS: psel=1, penable=1. On pready=1: capture prdata (reads only), resp_error=pslverr, go RESPOND. Else counter increments; when counter reaches TimeoutCycles-1 with pready=0: resp_error=1, resp_timeout=1, resp_data=0, go RESPOND.
- RESPOND: psel=penable=0, resp_valid=1, fields stable until resp_ready=1, then IDLE.
- pslverr=1 on a read forces resp_data=0.
- paddr/pwrite/pwdata hold latched values from SETUP through ACCESS; unchanged in RESPOND/IDLE.
- pready/pslverr/prdata ignored outside ACCESS.

## Timing
- Reset (asserted any time, including mid-transfer): state=IDLE; psel, penable, pwrite, resp_valid, resp_error, resp_timeout = 0; paddr, pwdata, resp_data = 0; counter=0; req_ready=1 after deassertion. No response emitted for aborted transfer.
- Request accepted on edge N (req_valid & req_ready): SETUP during N+1, ACCESS from N+2.
- Zero-wait peripheral (pready=1 in first ACCESS cycle): resp_valid=1 at N+3; minimum request-to-response latency 3 cycles.
- Each pready=0 ACCESS cycle adds one cycle.
- Timeout: with TimeoutCycles=T>0 and pready held 0, ACCESS lasts exactly T cycles; resp_valid at N+2+T.
- pready=1 on the same edge the counter would expire: completion wins, resp_timeout=0.
- resp_ready=1 in the first RESPOND cycle: IDLE next cycle, next request accepted one cycle later (back-to-back throughput 4 cycles).
- req_ready is combinational from state only (no path from req_valid).

## Structure
- address_t/data_t come from renode_pkg at default widths; add to renode_pkg a state enum apb_requester_state_e {IDLE, SETUP, ACCESS, RESPOND}.
- One sub-module: renode_timeout_counter (clear, enable, parameter Limit, expired output; Limit=0 never expires), reused by other bus requesters.

## Test plan
- Write 0xDEADBEEF to 0x1000, zero-wait slave -> one SETUP and one ACCESS cycle with paddr=0x1000, pwdata=0xDEADBEEF, pwrite=1; resp_valid at N+3, resp_error=0.
- Read 0x2004, slave returns 0x12345678 after 3 wait states -> resp_data=0x12345678 at N+6, resp_error=0.
- Read with pslverr=1 on completion -> resp_error=1, resp_timeout=0, resp_data=0.
- TimeoutCycles=4, pready stuck 0 -> psel drops after 4 ACCESS cycles, resp_error=1, resp_timeout=1; pready=1 exactly on 4th cycle -> normal completion.
- Hold resp_ready=0 for 10 cycles -> response fields stable, req_ready=0, new req_valid ignored; release -> accepted next IDLE.
- Assert rst_n=0 during ACCESS -> psel/penable/resp_valid 0 immediately (asynchronous); after release, next read completes normally.
